// File: rtl/score_keeper_if.sv
// Score keeper bus: event pulses from the collision logic in, and the
// game status and score towards the two-digit display out.
interface score_keeper_if;
    logic       start;
    logic       catch_evt;
    logic       miss_evt;
    logic [7:0] score;
    logic [7:0] high_score;
    logic [2:0] lives;
    logic       mult2;
    logic [1:0] state;
    logic       game_over;
    logic       score_changed;

    modport master (
        output start, catch_evt, miss_evt,
        input  score, high_score, lives, mult2, state, game_over, score_changed
    );

    modport slave (
        input  start, catch_evt, miss_evt,
        output score, high_score, lives, mult2, state, game_over, score_changed
    );
endinterface

// File: rtl/score_keeper.sv
// Game scoring stage: runs IDLE/PLAYING/GAME_OVER, tracks lives, catch
// streak, x2 multiplier and high score, and keeps the score within
// 0..MAX_SCORE so it always fits the two-digit display.
module score_keeper #(
    parameter int MAX_SCORE   = 99,
    parameter int START_LIVES = 3,
    parameter int STREAK_LEN  = 5
) (
    input  logic           CLK,
    input  logic           RST_BTN,
    score_keeper_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_PLAYING   = 2'b01,
        ST_GAME_OVER = 2'b10
    } state_t;

    localparam logic [8:0] MAX9       = 9'(MAX_SCORE);
    localparam logic [2:0] LIVES0     = 3'(START_LIVES);
    localparam logic [3:0] STREAK_MAX = 4'(STREAK_LEN);

    state_t     state_q;
    logic [7:0] score_q;
    logic [7:0] high_q;
    logic [2:0] lives_q;
    logic [3:0] streak_q;
    logic       mult2_q;
    logic       game_over_q;
    logic       changed_q;

    logic [7:0] nxt_score;
    logic [3:0] nxt_streak;
    logic       nxt_mult2;

    // Add in 9 bits so the sum can never wrap before it is clamped.
    function automatic logic [7:0] sat_score(input logic [7:0] cur, input logic [1:0] pts);
        logic [8:0] sum;
        sum = {1'b0, cur} + {7'd0, pts};
        if (sum > MAX9) sum = MAX9;
        return sum[7:0];
    endfunction

    function automatic logic [3:0] sat_streak(input logic [3:0] cur);
        if (cur >= STREAK_MAX) return STREAK_MAX;
        return cur + 4'd1;
    endfunction

    // Effect of a catch this cycle, using the multiplier as it stood before the edge.
    always_comb begin
        nxt_score  = score_q;
        nxt_streak = streak_q;
        nxt_mult2  = mult2_q;
        if (bus.catch_evt) begin
            nxt_score  = sat_score(score_q, mult2_q ? 2'd2 : 2'd1);
            nxt_streak = sat_streak(streak_q);
            nxt_mult2  = mult2_q | (nxt_streak == STREAK_MAX);
        end
    end

    // Game state machine; a simultaneous miss is applied after the catch has scored.
    always_ff @(posedge CLK) begin
        if (!RST_BTN) begin
            state_q     <= ST_IDLE;
            score_q     <= '0;
            high_q      <= '0;
            lives_q     <= '0;
            streak_q    <= '0;
            mult2_q     <= 1'b0;
            game_over_q <= 1'b0;
            changed_q   <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_GAME_OVER: begin
                    if (bus.start) begin
                        state_q     <= ST_PLAYING;
                        score_q     <= '0;
                        lives_q     <= LIVES0;
                        streak_q    <= '0;
                        mult2_q     <= 1'b0;
                        game_over_q <= 1'b0;
                        changed_q   <= (score_q != 8'd0);
                    end
                end
                ST_PLAYING: begin
                    score_q   <= nxt_score;
                    changed_q <= (nxt_score != score_q);
                    if (bus.miss_evt) begin
                        streak_q <= '0;
                        mult2_q  <= 1'b0;
                        lives_q  <= lives_q - 3'd1;
                        if (lives_q == 3'd1) begin
                            state_q     <= ST_GAME_OVER;
                            game_over_q <= 1'b1;
                            if (nxt_score > high_q) high_q <= nxt_score;
                        end
                    end else begin
                        streak_q <= nxt_streak;
                        mult2_q  <= nxt_mult2;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.score         = score_q;
    assign bus.high_score    = high_q;
    assign bus.lives         = lives_q;
    assign bus.mult2         = mult2_q;
    assign bus.state         = state_q;
    assign bus.game_over     = game_over_q;
    assign bus.score_changed = changed_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_score_keeper;

    logic CLK;
    logic RST_BTN;
    int   checks;
    int   errors;

    score_keeper_if sk_if ();

    score_keeper #(
        .MAX_SCORE  (99),
        .START_LIVES(3),
        .STREAK_LEN (5)
    ) dut (
        .CLK    (CLK),
        .RST_BTN(RST_BTN),
        .bus    (sk_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One clock with the given inputs applied; outputs are settled on return.
    task automatic step(input logic st, input logic c, input logic m, input logic r);
        @(negedge CLK);
        sk_if.start     = st;
        sk_if.catch_evt = c;
        sk_if.miss_evt  = m;
        RST_BTN         = r;
        @(posedge CLK);
        #1;
        sk_if.start     = 1'b0;
        sk_if.catch_evt = 1'b0;
        sk_if.miss_evt  = 1'b0;
        RST_BTN         = 1'b1;
    endtask

    task automatic test_reset;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (sk_if.state !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", sk_if.state); end
        checks++; if (sk_if.score !== 8'd0) begin errors++; $display("FAIL reset_score got %0d want 0", sk_if.score); end
        checks++; if (sk_if.high_score !== 8'd0) begin errors++; $display("FAIL reset_high got %0d want 0", sk_if.high_score); end
        checks++; if (sk_if.lives !== 3'd0) begin errors++; $display("FAIL reset_lives got %0d want 0", sk_if.lives); end
        checks++; if ({sk_if.mult2, sk_if.game_over, sk_if.score_changed} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {sk_if.mult2, sk_if.game_over, sk_if.score_changed}); end
        // catches in IDLE are ignored
        step(1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (sk_if.score !== 8'd0) begin errors++; $display("FAIL idle_catch score got %0d want 0", sk_if.score); end
    endtask

    task automatic test_start_catches;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (sk_if.state !== 2'b01) begin errors++; $display("FAIL start_state got %b want 01", sk_if.state); end
        checks++; if (sk_if.lives !== 3'd3) begin errors++; $display("FAIL start_lives got %0d want 3", sk_if.lives); end
        checks++; if (sk_if.score !== 8'd0) begin errors++; $display("FAIL start_score got %0d want 0", sk_if.score); end
        checks++; if (sk_if.score_changed !== 1'b0) begin errors++; $display("FAIL start_changed got %b want 0", sk_if.score_changed); end
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            checks++; if (sk_if.score !== 8'(i)) begin errors++; $display("FAIL catch%0d_score got %0d want %0d", i, sk_if.score, i); end
            checks++; if (sk_if.score_changed !== 1'b1) begin errors++; $display("FAIL catch%0d_changed got %b want 1", i, sk_if.score_changed); end
        end
        checks++; if (sk_if.mult2 !== 1'b0) begin errors++; $display("FAIL four_catch_mult2 got %b want 0", sk_if.mult2); end
    endtask

    task automatic test_multiplier;
        step(1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (sk_if.score !== 8'd5 || sk_if.mult2 !== 1'b1) begin
            errors++; $display("FAIL fifth_catch score/mult2 got %0d/%b want 5/1", sk_if.score, sk_if.mult2); end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (sk_if.score !== 8'd9) begin errors++; $display("FAIL doubled_score got %0d want 9", sk_if.score); end
        step(1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (sk_if.mult2 !== 1'b0 || sk_if.lives !== 3'd2) begin
            errors++; $display("FAIL miss mult2/lives got %b/%0d want 0/2", sk_if.mult2, sk_if.lives); end
        checks++; if (sk_if.score_changed !== 1'b0) begin errors++; $display("FAIL miss_changed got %b want 0", sk_if.score_changed); end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (sk_if.score !== 8'd10) begin errors++; $display("FAIL after_miss_score got %0d want 10", sk_if.score); end
        // start is ignored while playing
        step(1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (sk_if.score !== 8'd10 || sk_if.state !== 2'b01 || sk_if.lives !== 3'd2) begin
            errors++; $display("FAIL start_in_play score/state/lives got %0d/%b/%0d want 10/01/2", sk_if.score, sk_if.state, sk_if.lives); end
    endtask

    task automatic test_simultaneous;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (sk_if.score !== 8'd7) begin errors++; $display("FAIL six_catch_score got %0d want 7", sk_if.score); end
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (sk_if.lives !== 3'd1 || sk_if.mult2 !== 1'b0) begin
            errors++; $display("FAIL two_miss lives/mult2 got %0d/%b want 1/0", sk_if.lives, sk_if.mult2); end
        step(1'b0, 1'b1, 1'b1, 1'b1);
        checks++; if (sk_if.score !== 8'd8) begin errors++; $display("FAIL both_score got %0d want 8", sk_if.score); end
        checks++; if (sk_if.lives !== 3'd0) begin errors++; $display("FAIL both_lives got %0d want 0", sk_if.lives); end
        checks++; if (sk_if.state !== 2'b10 || sk_if.game_over !== 1'b1) begin
            errors++; $display("FAIL both_state state/game_over got %b/%b want 10/1", sk_if.state, sk_if.game_over); end
        checks++; if (sk_if.high_score !== 8'd8) begin errors++; $display("FAIL both_high got %0d want 8", sk_if.high_score); end
        checks++; if (sk_if.score_changed !== 1'b1) begin errors++; $display("FAIL both_changed got %b want 1", sk_if.score_changed); end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (sk_if.score !== 8'd8 || sk_if.score_changed !== 1'b0 || sk_if.state !== 2'b10) begin
            errors++; $display("FAIL over_catch score/changed/state got %0d/%b/%b want 8/0/10", sk_if.score, sk_if.score_changed, sk_if.state); end
        step(1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (sk_if.lives !== 3'd0 || sk_if.state !== 2'b10) begin
            errors++; $display("FAIL over_miss lives/state got %0d/%b want 0/10", sk_if.lives, sk_if.state); end
    endtask

    task automatic test_restart;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (sk_if.score !== 8'd0 || sk_if.lives !== 3'd3 || sk_if.high_score !== 8'd8) begin
            errors++; $display("FAIL restart score/lives/high got %0d/%0d/%0d want 0/3/8", sk_if.score, sk_if.lives, sk_if.high_score); end
        checks++; if (sk_if.state !== 2'b01 || sk_if.game_over !== 1'b0 || sk_if.score_changed !== 1'b1) begin
            errors++; $display("FAIL restart state/game_over/changed got %b/%b/%b want 01/0/1", sk_if.state, sk_if.game_over, sk_if.score_changed); end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (sk_if.state !== 2'b10 || sk_if.score !== 8'd5 || sk_if.high_score !== 8'd8) begin
            errors++; $display("FAIL low_game state/score/high got %b/%0d/%0d want 10/5/8", sk_if.state, sk_if.score, sk_if.high_score); end
    endtask

    task automatic test_saturation;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (sk_if.score !== 8'd10 || sk_if.mult2 !== 1'b1) begin
            errors++; $display("FAIL sat_setup score/mult2 got %0d/%b want 10/1", sk_if.score, sk_if.mult2); end
        for (int i = 0; i < 44; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (sk_if.score !== 8'd98) begin errors++; $display("FAIL sat_98 got %0d want 98", sk_if.score); end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (sk_if.score !== 8'd99 || sk_if.score_changed !== 1'b1) begin
            errors++; $display("FAIL sat_99 score/changed got %0d/%b want 99/1", sk_if.score, sk_if.score_changed); end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (sk_if.score !== 8'd99 || sk_if.score_changed !== 1'b0) begin
            errors++; $display("FAIL sat_hold score/changed got %0d/%b want 99/0", sk_if.score, sk_if.score_changed); end
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (sk_if.state !== 2'b10 || sk_if.high_score !== 8'd99) begin
            errors++; $display("FAIL sat_high state/high got %b/%0d want 10/99", sk_if.state, sk_if.high_score); end
    endtask

    task automatic test_mid_reset;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (sk_if.score !== 8'd2) begin errors++; $display("FAIL pre_reset_score got %0d want 2", sk_if.score); end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (sk_if.state !== 2'b00 || sk_if.score !== 8'd0 || sk_if.lives !== 3'd0 || sk_if.high_score !== 8'd0) begin
            errors++; $display("FAIL mid_reset state/score/lives/high got %b/%0d/%0d/%0d want 00/0/0/0",
                               sk_if.state, sk_if.score, sk_if.lives, sk_if.high_score); end
        checks++; if ({sk_if.mult2, sk_if.game_over, sk_if.score_changed} !== 3'b000) begin
            errors++; $display("FAIL mid_reset_flags got %b want 000", {sk_if.mult2, sk_if.game_over, sk_if.score_changed}); end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (sk_if.score !== 8'd0 || sk_if.state !== 2'b00) begin
            errors++; $display("FAIL post_reset score/state got %0d/%b want 0/00", sk_if.score, sk_if.state); end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        RST_BTN         = 1'b0;
        sk_if.start     = 1'b0;
        sk_if.catch_evt = 1'b0;
        sk_if.miss_evt  = 1'b0;
        test_reset();
        test_start_catches();
        test_multiplier();
        test_simultaneous();
        test_restart();
        test_saturation();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-scoring stage directly upstream of the two-digit score display.
- Consumes one-cycle catch/miss event pulses from the collision logic.
- Runs the game state machine (IDLE/PLAYING/GAME_OVER) and maintains lives, catch streak, multiplier and high score.
- Drives the 8-bit binary score bus into the display; score is always 0..MAX_SCORE so it fits two BCD digits.

Parameters:
- MAX_SCORE, 99, saturation ceiling for score and high_score; must be ≤ 255.
- START_LIVES, 3, lives loaded on game start; range 1..7.
- STREAK_LEN, 5, consecutive catches needed to arm the ×2 multiplier; range 1..15.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_BTN  in  1  synchronous, active-low reset: 0 sampled at a CLK rising edge resets the block.
- start  in  1  one-cycle pulse; begins a game from IDLE or GAME_OVER; ignored in PLAYING.
- catch_evt  in  1  one-cycle pulse; snowflake caught.
- miss_evt  in  1  one-cycle pulse; snowflake missed.
- score  out  8  current score, binary, feeds the display.
- high_score  out  8  best final score since reset.
- lives  out  3  remaining lives.
- mult2  out  1  1 = ×2 multiplier active.
- state  out  2  00 IDLE, 01 PLAYING, 10 GAME_OVER.
- game_over  out  1  level: 1 while state = GAME_OVER.
- score_changed  out  1  one-cycle pulse in the cycle score takes a new value.

Behaviour:
- Reset (RST_BTN=0 at an edge):
  - state=IDLE; score=0, high_score=0, lives=0, mult2=0, game_over=0, score_changed=0.
  - Internal streak counter=0.
  - Reset overrides all other inputs in the same cycle, including mid-game.
- All outputs are registered. An event sampled at edge N is visible after edge N (1-cycle latency).
- IDLE:
  - catch_evt/miss_evt ignored.
  - start → PLAYING: score=0, lives=START_LIVES, streak=0, mult2=0, score_changed=1 if score was nonzero.
- PLAYING, catch_evt=1:
  - Points added = 2 if mult2=1 before this edge, else 1.
  - score = min(score + points, MAX_SCORE). Compute in 9 bits; no 8-bit wraparound is ever permitted.
  - score_changed=1 only if the value actually changes (no pulse while held at MAX_SCORE).
  - streak = min(streak+1, STREAK_LEN). mult2=1 when streak reaches STREAK_LEN.
- PLAYING, miss_evt=1:
  - streak=0, mult2=0, lives=lives-1.
  - If lives becomes 0: → GAME_OVER; high_score = max(high_score, final score) in the same edge.
- PLAYING, catch_evt and miss_evt in the same cycle:
  - The catch scores using the pre-edge mult2.
  - The miss then applies: streak=0, mult2=0, lives decrement, and the game-over check uses the post-catch score.
- PLAYING, start: ignored.
- GAME_OVER:
  - score and lives hold; events ignored; game_over=1.
  - start → PLAYING, same init as from IDLE; high_score retained.
- lives never underflows: a miss is only processed in PLAYING, where lives ≥ 1.
- Inputs are assumed synchronous to CLK and single-cycle. Back-to-back pulses on consecutive cycles must each be counted.

Test Plan:
- Reset then start pulse → state=01, lives=3, score=0; 4 catches on consecutive cycles → score=4, mult2=0, four score_changed pulses.
- 5 catches → mult2=1 after the 5th; 2 more catches → score=5+2+2=9; one miss → mult2=0, lives=2; next catch → score=10.
- Drive score to 98 with mult2=1; catch → score=99, score_changed=1; further catch → score=99, no score_changed pulse.
- Score=7, lives=1; catch_evt and miss_evt in the same cycle → score=8, lives=0, state=10, high_score=8; a catch in GAME_OVER leaves score=8.
- From GAME_OVER (high_score=8): start → score=0, lives=3, high_score=8. End the next game at score 5 → high_score stays 8.
- Mid-game RST_BTN=0 for one cycle with catch_evt=1 in the same cycle → all outputs 0, state=IDLE, and the catch is not counted.
